mac_sequencer: RTL and testbench

Job-level controller for one `processing_unit` multiply-accumulate cell. It accepts a dot-product command of length N and clears the cell's accumulator. It then streams N FP16 operand pairs through the cell's start/ready handshake and returns the accumulated result on a valid/ready port. A watchdog aborts a job when the cell stops responding.

---
 rtl/mac_seq_pkg.sv | 28 ++
 rtl/mac_seq_watchdog.sv | 41 ++++
 rtl/mac_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mac_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// ============================================================================
// Module   : mac_seq_pkg
// Brief    : Shared types and constants for the mac_sequencer job controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_seq_pkg;

    // Controller states; the encoding is fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH   = 3'd2,
        S_ISSUE   = 3'd3,
        S_RELEASE = 3'd4,
        S_DRAIN   = 3'd5,
        S_RESULT  = 3'd6
    } state_t;

    // Result for an empty dot product.
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    // Quiet NaN returned when the watchdog aborts a job.
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

endpackage

`default_nettype wire

// File: rtl/mac_seq_watchdog.sv
// ============================================================================
// Module   : mac_seq_watchdog
// Brief    : Saturating cycle counter that flags a stalled handshake phase.
//            'expired' is high in the cycle whose closing edge brings the
//            count to TIMEOUT, so a phase may last exactly TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_watchdog #(
    parameter int TIMEOUT = 64,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent in a watched phase; restart on phase entry, hold at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Expiry is announced one count early so the abort lands on the edge the count hits TIMEOUT.
    always_comb begin
        expired = run && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

endmodule

`default_nettype wire

// File: rtl/mac_sequencer.sv
// ============================================================================
// Module   : mac_sequencer
// Brief    : Job-level controller for one multiply-accumulate cell. Accepts a
//            length-N dot-product command, clears the cell, streams N FP16
//            operand pairs through the cell handshake and returns the
//            accumulated result. A watchdog aborts jobs on a stalled cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_err,
    output logic             busy,
    output logic             pu_rst,
    output logic             pu_start,
    output logic [15:0]      pu_a,
    output logic [15:0]      pu_b,
    input  logic [15:0]      pu_p,
    input  logic             pu_ready
);

    state_t            state_q,    state_d;
    logic [LEN_W-1:0]  rem_q,      rem_d;
    logic              pu_rst_q,   pu_rst_d;
    logic              pu_start_q, pu_start_d;
    logic [15:0]       pu_a_q,     pu_a_d;
    logic [15:0]       pu_b_q,     pu_b_d;
    logic [15:0]       res_data_q, res_data_d;
    logic              res_err_q,  res_err_d;

    logic              wd_clear;
    logic              wd_run;
    logic              wd_expired;
    logic [LEN_W-1:0]  len_sat;
    logic [LEN_W-1:0]  rem_dec;

    // Watchdog restarts on the edges that enter S_ISSUE or S_RELEASE. These
    // conditions are taken from inputs only, so they never depend on expiry.
    always_comb begin
        wd_run   = (state_q == S_ISSUE) || (state_q == S_RELEASE);
        wd_clear = ((state_q == S_FETCH) && op_valid) ||
                   ((state_q == S_ISSUE) && pu_ready);
    end

    mac_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // Saturate oversized commands and keep the pair counter from wrapping.
    always_comb begin
        len_sat = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        rem_dec = (rem_q == '0) ? '0 : (rem_q - LEN_W'(1));
    end

    // State and datapath registers; the cell is held in reset while we are.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            pu_rst_q   <= 1'b1;
            pu_start_q <= 1'b0;
            pu_a_q     <= '0;
            pu_b_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            pu_rst_q   <= pu_rst_d;
            pu_start_q <= pu_start_d;
            pu_a_q     <= pu_a_d;
            pu_b_q     <= pu_b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Next-state and next-datapath logic for the job sequence.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pu_start_d = pu_start_q;
        pu_a_d     = pu_a_q;
        pu_b_d     = pu_b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rem_d = len_sat;
                    if (len_sat == '0) begin
                        // Empty job completes without touching the cell.
                        res_data_d = FP16_ZERO;
                        res_err_d  = 1'b0;
                        state_d    = S_RESULT;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (op_valid) begin
                    pu_a_d     = op_a;
                    pu_b_d     = op_b;
                    pu_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Completion takes priority over a simultaneous expiry.
                if (pu_ready) begin
                    pu_start_d = 1'b0;
                    state_d    = S_RELEASE;
                end else if (wd_expired) begin
                    pu_start_d = 1'b0;
                    res_err_d  = 1'b1;
                    res_data_d = FP16_QNAN;
                    rem_d      = rem_dec;
                    state_d    = (rem_dec != '0) ? S_DRAIN : S_RESULT;
                end
            end

            S_RELEASE: begin
                // P is only trustworthy once the cell has dropped ready.
                if (!pu_ready) begin
                    rem_d = rem_dec;
                    if (rem_dec == '0) begin
                        res_data_d = pu_p;
                        state_d    = S_RESULT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wd_expired) begin
                    res_err_d  = 1'b1;
                    res_data_d = FP16_QNAN;
                    rem_d      = rem_dec;
                    state_d    = (rem_dec != '0) ? S_DRAIN : S_RESULT;
                end
            end

            S_DRAIN: begin
                // Swallow the rest of the aborted job's operands.
                if (op_valid) begin
                    rem_d = rem_dec;
                    if (rem_dec == '0) begin
                        state_d = S_RESULT;
                    end
                end
            end

            S_RESULT: begin
                if (res_ready) begin
                    res_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The cell reset is a one-cycle pulse that coincides with S_CLEAR.
    always_comb begin
        pu_rst_d = (state_d == S_CLEAR);
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        op_ready  = (state_q == S_FETCH) || (state_q == S_DRAIN);
        res_valid = (state_q == S_RESULT);
        busy      = (state_q != S_IDLE);
        pu_rst    = pu_rst_q;
        pu_start  = pu_start_q;
        pu_a      = pu_a_q;
        pu_b      = pu_b_q;
        res_data  = res_data_q;
        res_err   = res_err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// ============================================================================
// Module   : tb_mac_sequencer
// Brief    : Self-checking bench for mac_sequencer with a behavioural FP16
//            multiply-accumulate cell (optionally "dead" to stall ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_sequencer;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid, op_ready;
    logic [15:0]      op_a, op_b;
    logic             res_valid, res_ready;
    logic [15:0]      res_data;
    logic             res_err, busy;
    logic             pu_rst, pu_start;
    logic [15:0]      pu_a, pu_b, pu_p;
    logic             pu_ready;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_rst    = 0;
    logic start_prev = 1'b0;
    bit   cell_dead  = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy),
        .pu_rst    (pu_rst),
        .pu_start  (pu_start),
        .pu_a      (pu_a),
        .pu_b      (pu_b),
        .pu_p      (pu_p),
        .pu_ready  (pu_ready)
    );

    // ---------------- FP16 helpers (normal numbers only) ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) r = (real'(h[9:0]) / 1024.0) * pow2(-14);
        else        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
        if (h[15]) r = -r;
        return r;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real  r;
        int   e, m;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        r = s ? -x : x;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m = int'((r - 1.0) * 1024.0);
        return {s, e[4:0], m[9:0]};
    endfunction

    // ---------------- behavioural cell: latency 3, ready held until start drops
    logic       c_busy = 1'b0;
    int         c_cnt  = 0;
    logic       c_rdy  = 1'b0;
    logic [15:0] c_p   = 16'h0;
    assign pu_ready = c_rdy;
    assign pu_p     = c_p;

    always @(posedge clk) begin
        if (pu_rst) begin
            c_p    <= 16'h0;
            c_rdy  <= 1'b0;
            c_busy <= 1'b0;
        end else if (c_rdy) begin
            if (!pu_start) c_rdy <= 1'b0;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                c_p    <= r2h(h2r(c_p) + h2r(pu_a) * h2r(pu_b));
                c_rdy  <= 1'b1;
                c_busy <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (pu_start && !cell_dead) begin
            c_busy <= 1'b1;
            c_cnt  <= 2;
        end
    end

    // Count pu_start rising edges and pu_rst-high cycles.
    always @(posedge clk) begin
        start_prev <= pu_start;
        if (pu_start && !start_prev) n_starts <= n_starts + 1;
        if (pu_rst) n_rst <= n_rst + 1;
    end

    // ---------------- checking / driving tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input int len);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        t = 0;
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        int t;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        t = 0;
        while (!op_ready && t < 300) begin @(negedge clk); t++; end
        if (!op_ready) check("op_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_result();
        int t;
        @(negedge clk);
        t = 0;
        while (!res_valid && t < 300) begin @(negedge clk); t++; end
        if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_result(output logic [15:0] d, output logic e);
        wait_result();
        d = res_data;
        e = res_err;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]      exp_data;
        logic             exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] d, d0;
        logic        e;
        int          s0, r0, n;
        bit          stable;

        // 1*2 + 3*1 + 0.5*4 = 7
        vecs[0] = '{3, {16'h0, 16'h3800, 16'h4200, 16'h3C00}, {16'h0, 16'h4400, 16'h3C00, 16'h4000}, 16'h4700, 1'b0};
        // 2*2 = 4 (would be 11 = 4980 if the cell were not cleared)
        vecs[1] = '{1, {16'h0, 16'h0, 16'h0, 16'h4000}, {16'h0, 16'h0, 16'h0, 16'h4000}, 16'h4400, 1'b0};
        vecs[2] = '{0, {16'h0, 16'h0, 16'h0, 16'h0}, {16'h0, 16'h0, 16'h0, 16'h0}, 16'h0000, 1'b0};
        // 2*3 + 1*1 = 7
        vecs[3] = '{2, {16'h0, 16'h0, 16'h3C00, 16'h4000}, {16'h0, 16'h0, 16'h3C00, 16'h4200}, 16'h4700, 1'b0};
        vecs[4] = '{1, {16'h0, 16'h0, 16'h0, 16'h3C00}, {16'h0, 16'h0, 16'h0, 16'h3C00}, 16'h3C00, 1'b0};
        // 4*0.5 + (-1)*2 = 0
        vecs[5] = '{2, {16'h0, 16'h0, 16'hBC00, 16'h4400}, {16'h0, 16'h0, 16'h4000, 16'h3800}, 16'h0000, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pu_rst",    32'(pu_rst),    32'd1);
        check("rst_pu_start",  32'(pu_start),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_ready",  32'(op_ready),  32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_err",   32'(res_err),   32'd0);
        check("rst_pu_a",      32'(pu_a),      32'd0);
        reset = 1'b0;
        #1 check("pu_rst_held_before_edge", 32'(pu_rst), 32'd1);
        @(posedge clk);
        #1;
        check("pu_rst_falls_first_edge", 32'(pu_rst), 32'd0);
        check("idle_cmd_ready",          32'(cmd_ready), 32'd1);

        // Empty job: result right after accept, cell untouched
        s0 = n_starts; r0 = n_rst;
        send_cmd(0);
        check("len0_res_valid_after_accept", 32'(res_valid), 32'd1);
        check("len0_cmd_ready_low",          32'(cmd_ready), 32'd0);
        get_result(d, e);
        check("len0_data",      32'(d), 32'h0000);
        check("len0_err",       32'(e), 32'd0);
        check("len0_no_start",  32'(n_starts - s0), 32'd0);
        check("len0_no_pu_rst", 32'(n_rst - r0), 32'd0);

        // Table-driven jobs, back to back
        for (int i = 0; i < 6; i++) begin
            s0 = n_starts; r0 = n_rst;
            send_cmd(vecs[i].len);
            for (int j = 0; j < vecs[i].len; j++) send_op(vecs[i].a[j], vecs[i].b[j]);
            get_result(d, e);
            check($sformatf("vec%0d_data", i),   32'(d), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),    32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_starts", i), 32'(n_starts - s0), 32'(vecs[i].len));
            check($sformatf("vec%0d_clears", i), 32'(n_rst - r0), (vecs[i].len > 0) ? 32'd1 : 32'd0);
        end

        // Result back-pressure: 20 stalled cycles with a competing command
        send_cmd(1);
        send_op(16'h4000, 16'h4000);
        wait_result();
        d0 = res_data;
        cmd_valid = 1'b1; cmd_len = LEN_W'(1);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid || res_data !== d0 || cmd_ready || !busy) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_data",   32'(d0), 32'h4400);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("bp_cmd_not_taken", 32'(busy), 32'd0);

        // Oversized length saturates to MAX_LEN: 8 * (1*1) = 8
        s0 = n_starts;
        send_cmd(12);
        for (int j = 0; j < MAX_LEN; j++) send_op(16'h3C00, 16'h3C00);
        get_result(d, e);
        check("sat_data",   32'(d), 32'h4800);
        check("sat_starts", 32'(n_starts - s0), 32'(MAX_LEN));

        // Watchdog abort with a dead cell
        cell_dead = 1'b1;
        s0 = n_starts;
        send_cmd(4);
        send_op(16'h3C00, 16'h4000);
        n = 0;
        @(negedge clk);
        while (pu_start && n < 100) begin n++; @(negedge clk); end
        check("wd_start_cycles", 32'(n), 32'(TIMEOUT));
        check("wd_drain_op_ready", 32'(op_ready), 32'd1);
        for (int j = 0; j < 3; j++) send_op(16'h4000, 16'h4000);
        @(negedge clk);
        check("wd_result_after_drain", 32'(res_valid), 32'd1);
        get_result(d, e);
        check("wd_data",   32'(d), 32'h7E00);
        check("wd_err",    32'(e), 32'd1);
        check("wd_starts", 32'(n_starts - s0), 32'd1);
        cell_dead = 1'b0;
        send_cmd(1);
        send_op(16'h3C00, 16'h3C00);
        get_result(d, e);
        check("post_wd_err",  32'(e), 32'd0);
        check("post_wd_data", 32'(d), 32'h3C00);

        // Reset in S_ISSUE of element 2
        send_cmd(3);
        send_op(16'h3C00, 16'h4000);
        send_op(16'h4200, 16'h3C00);
        check("mid_in_issue", 32'(pu_start), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_pu_rst",    32'(pu_rst),    32'd1);
        check("mid_pu_start",  32'(pu_start),  32'd0);
        check("mid_busy",      32'(busy),      32'd0);
        check("mid_op_ready",  32'(op_ready),  32'd0);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_pu_a",      32'(pu_a),      32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("mid_pu_rst_release", 32'(pu_rst), 32'd0);
        send_cmd(1);
        send_op(16'h3C00, 16'h3C00);
        get_result(d, e);
        check("mid_next_data", 32'(d), 32'h3C00);
        check("mid_next_err",  32'(e), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
